// File: rtl/alu_seq_unit.sv
// alu_seq_unit: operand-register ALU with single-cycle logic/arithmetic
// and iterative one-bit-per-cycle shifts; result and ZF/CF/OF/SF are registered.
`default_nettype none

module alu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_a,
  input  logic             load_b,
  input  logic [3:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             cf,
  output logic             of,
  output logic             sf
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FIN = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic [3:0]       op_r;

  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cf;
  logic             alu_of;
  logic [WIDTH-1:0] shifted;
  logic [SHW-1:0]   shamt;
  logic             is_shift;

  assign shamt    = b_reg[SHW-1:0];
  assign is_shift = (op == 4'd8) || (op == 4'd9) || (op == 4'd10);

  // Single-cycle datapath on the pre-edge operand registers
  always_comb begin
    sum_add = {1'b0, a_reg} + {1'b0, b_reg};
    sum_sub = {1'b0, a_reg} + {1'b0, ~b_reg} + {{WIDTH{1'b0}}, 1'b1};
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (op)
      4'd0: begin
        alu_res = sum_add[WIDTH-1:0];
        alu_cf  = sum_add[WIDTH];
        alu_of  = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (alu_res[WIDTH-1] != a_reg[WIDTH-1]);
      end
      4'd1: begin
        alu_res = sum_sub[WIDTH-1:0];
        alu_cf  = ~sum_sub[WIDTH];
        alu_of  = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (alu_res[WIDTH-1] != a_reg[WIDTH-1]);
      end
      4'd2:  alu_res = a_reg & b_reg;
      4'd3:  alu_res = a_reg | b_reg;
      4'd4:  alu_res = a_reg ^ b_reg;
      4'd5:  alu_res = ~(a_reg | b_reg);
      4'd6:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
      4'd7:  alu_res = {{(WIDTH-1){1'b0}}, (a_reg < b_reg)};
      // Zero-amount shifts complete here and pass A through
      4'd8, 4'd9, 4'd10: alu_res = a_reg;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (op_r)
      4'd8:    shifted = {work[WIDTH-2:0], 1'b0};
      4'd9:    shifted = {1'b0, work[WIDTH-1:1]};
      default: shifted = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      work   <= '0;
      cnt    <= '0;
      op_r   <= '0;
      result <= '0;
      zf     <= 1'b0;
      cf     <= 1'b0;
      of     <= 1'b0;
      sf     <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      if (load_a) a_reg <= din;
      if (load_b) b_reg <= din;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r <= op;
            if (is_shift && (shamt != '0)) begin
              work  <= a_reg;
              cnt   <= shamt;
              busy  <= 1'b1;
              state <= SHIFT;
            end else begin
              result <= alu_res;
              zf     <= (alu_res == '0);
              sf     <= alu_res[WIDTH-1];
              cf     <= alu_cf;
              of     <= alu_of;
              done   <= 1'b1;
              state  <= FIN;
            end
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            result <= shifted;
            zf     <= (shifted == '0);
            sf     <= shifted[WIDTH-1];
            cf     <= 1'b0;
            of     <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed sequence with a scoreboard of expected results/latencies.
`default_nettype none

module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic        load_a = 1'b0;
  logic        load_b = 1'b0;
  logic [3:0]  op = '0;
  logic        start = 1'b0;
  logic        busy, done, zf, cf, of, sf;
  logic [31:0] result;

  alu_seq_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .din(din), .load_a(load_a), .load_b(load_b),
    .op(op), .start(start), .busy(busy), .done(done), .result(result),
    .zf(zf), .cf(cf), .of(of), .sf(sf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [3:0]  fl;   // {zf, cf, of, sf}
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.tag, "_result"}, 64'(result), 64'(e.res));
        check({e.tag, "_flags"}, 64'({zf, cf, of, sf}), 64'(e.fl));
        check({e.tag, "_latency"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] av, input logic [31:0] bv);
    din = av; load_a = 1'b1; tick(); load_a = 1'b0;
    din = bv; load_b = 1'b1; tick(); load_b = 1'b0;
  endtask

  // Pulses start for one cycle and records expected result and done cycle
  task automatic launch(input string tag, input logic [3:0] opc, input logic [31:0] res,
                        input logic [3:0] fl, input int n);
    exp_t e;
    e.tag = tag; e.res = res; e.fl = fl; e.cyc = cyc + 1 + n;
    q.push_back(e);
    op = opc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    check({tag, "_timeout"}, 64'(q.size()), 64'd0);
    tick();
  endtask

  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [3:0] opc, input logic [31:0] res, input logic [3:0] fl,
                     input int n);
    load(av, bv);
    launch(tag, opc, res, fl, n);
    wait_idle(tag);
  endtask

  initial begin
    int bcnt;
    #1;
    check("reset_outputs", 64'({result, zf, cf, of, sf, done, busy}), 64'd0);
    #20;
    tick();
    rst = 1'b0;
    tick();

    run("add_carry",  32'hFFFF_FFFF, 32'h1, 4'd0, 32'h0,         4'b1100, 0);
    run("add_ovf",    32'h7FFF_FFFF, 32'h1, 4'd0, 32'h8000_0000, 4'b0011, 0);
    run("sub_borrow", 32'h0,         32'h1, 4'd1, 32'hFFFF_FFFF, 4'b0101, 0);
    run("sub_ovf",    32'h8000_0000, 32'h1, 4'd1, 32'h7FFF_FFFF, 4'b0010, 0);
    run("xor",        32'hF0F0_F0F0, 32'hFF00_FF00, 4'd4, 32'h0FF0_0FF0, 4'b0000, 0);
    run("nor",        32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5, 32'h000F_000F, 4'b0000, 0);

    // SRA by 4: busy for exactly 4 cycles, A reload mid-shift ignored
    load(32'h8000_0000, 32'h4);
    launch("sra4", 4'd10, 32'hF800_0000, 4'b0001, 4);
    bcnt = 0;
    din = 32'h1234_5678; load_a = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      if (busy) bcnt++;
      tick();
      load_a = 1'b0;
    end
    check("sra4_busy_cycles", 64'(bcnt), 64'd4);
    wait_idle("sra4");

    // SLL by 31 with a stray start mid-shift
    load(32'h1, 32'h1F);
    launch("sll31", 4'd8, 32'h8000_0000, 4'b0001, 31);
    repeat (5) tick();
    op = 4'd0; start = 1'b1; tick(); start = 1'b0;
    check("sll31_busy_mid", 64'(busy), 64'd1);
    wait_idle("sll31");

    run("slt",   32'hFFFF_FFFF, 32'h1, 4'd6,  32'h1, 4'b0000, 0);
    run("sltu",  32'hFFFF_FFFF, 32'h1, 4'd7,  32'h0, 4'b1000, 0);
    run("rsvd",  32'hFFFF_FFFF, 32'h1, 4'd12, 32'h0, 4'b1000, 0);

    // Reset asserted mid-shift aborts with no done
    load(32'hFFFF_0000, 32'h8);
    launch("srl_abort", 4'd9, 32'h00FF_FF00, 4'b0000, 8);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("midshift_reset_outputs", 64'({result, zf, cf, of, sf, done, busy}), 64'd0);
    q.delete();
    tick(); tick();
    rst = 1'b0;
    repeat (12) tick();
    check("post_reset_busy", 64'(busy), 64'd0);

    run("add_after_reset", 32'd5, 32'd7, 4'd0, 32'd12, 4'b0000, 0);
    run("srl_amt0", 32'h89AB_CDEF, 32'h20, 4'd9, 32'h89AB_CDEF, 4'b0001, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, single-clock successor to the board-level ALU datapath.
- Holds operands A and B in internal registers loaded by strobes from a shared data bus.
- Runs one operation per start command. Logic and arithmetic operations are single-cycle; shifts are iterative, one bit per cycle.
- Registers the result and the ZF/CF/OF/SF flags for the display/LED path and for later CPU reuse.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and a power of two.
- SHW, log2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  WIDTH  operand load bus
- load_a  in  1  capture din into A register
- load_b  in  1  capture din into B register
- op  in  4  operation code, sampled on accepted start
- start  in  1  request operation; accepted only when busy=0
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when result/flags update
- result  out  WIDTH  registered result
- zf  out  1  zero flag
- cf  out  1  carry/borrow flag
- of  out  1  signed overflow flag
- sf  out  1  sign flag (result MSB)

Behaviour:
- Reset (async, rst=1): A, B, result, zf, cf, of, sf, done, busy all 0; FSM to IDLE; shift counter 0. Reset mid-operation aborts with no done pulse.
- Operand registers:
  - load_a/load_b update A/B on the edge, in any state.
  - Loads during busy do not affect the in-flight op, because operands are copied to working registers on start.
  - If load and start occur in the same cycle, start uses pre-edge A/B.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed, result 1/0), 7 SLTU (unsigned)
  - 8 SLL, 9 SRL, 10 SRA; shift amount is B[SHW-1:0], A is shifted
  - 11-15 reserved: result 0, zf=1, others 0, single-cycle
- FSM:
  - IDLE: start=1 → accept. Non-shift op, or shift with amount 0 → compute, go to FIN. Shift with amount>0 → load work=A, cnt=amount, busy=1, go to SHIFT.
  - SHIFT: each cycle shift work one bit (SLL zero-fill, SRL zero-fill, SRA sign-fill) and decrement cnt. When cnt reaches 1, the final shift goes to FIN.
  - FIN (one cycle): result and flags valid, done=1, busy=0, return to IDLE.
  - start is ignored in SHIFT and FIN; no queueing.
- Latency:
  - Single-cycle ops: done asserted in the cycle after start is sampled (1-cycle latency).
  - Shift with amount N>0: done N+1 cycles after start.
  - busy is high only in SHIFT.
- result/flags hold their last value until the next done.
- Flags:
  - zf = (result==0); sf = result[WIDTH-1]
  - ADD: cf = carry out of bit WIDTH-1; of = operands same sign and result sign differs
  - SUB: cf = borrow (A<B unsigned); of = operands differ in sign and result sign ≠ A sign
  - Logic, SLT/SLTU, shifts: cf=0, of=0
- Arithmetic: modulo 2^WIDTH, computed with a WIDTH+1 bit adder; SUB = A + ~B + 1 with cf inverted carry.

Test Plan:
- WIDTH=32: load A=0xFFFFFFFF, B=0x00000001, ADD → after 1 cycle result=0, zf=1, cf=1, of=0, sf=0, done pulse 1 cycle.
- A=0x7FFFFFFF, B=1, ADD → result=0x80000000, of=1, sf=1, cf=0. Then SUB with A=0, B=1 → result=0xFFFFFFFF, cf=1, of=0.
- A=0x80000000, B=4, SRA → busy high 4 cycles, done at cycle 5, result=0xF8000000. A load_a of 0x12345678 during busy does not change that result.
- A=0x1, B=0x1F, SLL → done 32 cycles after start, result=0x80000000. A start pulsed mid-shift is ignored.
- SLT with A=0xFFFFFFFF, B=1 → result=1; SLTU with the same operands → result=0, zf=1. op=12 → result=0, zf=1.
- Assert rst during SHIFT → all outputs 0 immediately, no done. After release, a new ADD completes normally; shift amount 0 SRL completes in 1 cycle with result=A.
